// File: rtl/tick_cfg_if.sv
// Shared configuration write port for tick_generator.
// One write per wr_en cycle selects a channel and loads its ratio and mode.
interface tick_cfg_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [WIDTH-1:0] wr_ratio;
  logic             wr_oneshot;

  modport master (output wr_en, output wr_ch, output wr_ratio, output wr_oneshot);
  modport slave  (input  wr_en, input  wr_ch, input  wr_ratio, input  wr_oneshot);
endinterface

// File: rtl/tick_generator.sv
// Multi-channel programmable divider: per-channel tick pulse, 50% slow clock and one-shot done flag,
// with a shared write port and a global sync that phase-aligns all channels.
module tick_generator #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEFAULT_RATIO = 50_000_000
) (
  input  logic                pin_clock,
  input  logic                pin_n_reset,
  input  logic [CHANNELS-1:0] ch_enable,
  input  logic                sync,
  tick_cfg_if.slave           cfg,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] slow_clock,
  output logic [CHANNELS-1:0] done
);

  logic [WIDTH-1:0]    ratio_r [CHANNELS];
  logic [WIDTH-1:0]    count_r [CHANNELS];
  logic [CHANNELS-1:0] oneshot_r;
  logic [CHANNELS-1:0] tick_r;
  logic [CHANNELS-1:0] slow_r;
  logic [CHANNELS-1:0] done_r;
  logic [CHANNELS-1:0] wr_sel_s;

  // Decode the write target; an index >= CHANNELS matches no channel and is dropped.
  always_comb begin
    wr_sel_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.wr_en && (cfg.wr_ch == 4'(i))) begin
        wr_sel_s[i] = 1'b1;
      end else begin
        wr_sel_s[i] = 1'b0;
      end
    end
  end

  // Per-channel state: reset > sync > write > counting.
  always_ff @(posedge pin_clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!pin_n_reset) begin
        ratio_r[i]   <= WIDTH'(DEFAULT_RATIO);
        oneshot_r[i] <= 1'b0;
        count_r[i]   <= '0;
        tick_r[i]    <= 1'b0;
        slow_r[i]    <= 1'b0;
        done_r[i]    <= 1'b0;
      end else if (sync) begin
        // A concurrent write still lands its ratio/mode; sync owns the clearing.
        if (wr_sel_s[i]) begin
          ratio_r[i]   <= cfg.wr_ratio;
          oneshot_r[i] <= cfg.wr_oneshot;
        end
        count_r[i] <= '0;
        tick_r[i]  <= 1'b0;
        slow_r[i]  <= 1'b0;
        done_r[i]  <= 1'b0;
      end else if (wr_sel_s[i]) begin
        ratio_r[i]   <= cfg.wr_ratio;
        oneshot_r[i] <= cfg.wr_oneshot;
        count_r[i]   <= '0;
        tick_r[i]    <= 1'b0;
        done_r[i]    <= 1'b0;
      end else if (ch_enable[i] && (ratio_r[i] != '0) && !done_r[i]) begin
        // ratio is non-zero here, so ratio-1 cannot underflow.
        if (count_r[i] == (ratio_r[i] - WIDTH'(1))) begin
          count_r[i] <= '0;
          tick_r[i]  <= 1'b1;
          slow_r[i]  <= ~slow_r[i];
          done_r[i]  <= oneshot_r[i];
        end else begin
          count_r[i] <= count_r[i] + WIDTH'(1);
          tick_r[i]  <= 1'b0;
        end
      end else begin
        tick_r[i] <= 1'b0;
      end
    end
  end

  assign tick       = tick_r;
  assign slow_clock = slow_r;
  assign done       = done_r;

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator: directed scenarios plus random traffic, all checked every cycle
// against a step-count/modulo reference model.
module tb_tick_generator;
  localparam int CH  = 4;
  localparam int W   = 32;
  localparam int DEF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_reset;
  logic [CH-1:0] en;
  logic          sync;
  logic [CH-1:0] tick;
  logic [CH-1:0] slow_clock;
  logic [CH-1:0] done;

  tick_cfg_if #(.WIDTH(W)) cfg ();

  tick_generator #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_RATIO(DEF)) dut (
    .pin_clock   (clk),
    .pin_n_reset (n_reset),
    .ch_enable   (en),
    .sync        (sync),
    .cfg         (cfg),
    .tick        (tick),
    .slow_clock  (slow_clock),
    .done        (done)
  );

  // Reference model: a channel ticks whenever its count of productive edges since
  // the last restart is a multiple of its ratio.
  longint        m_r     [CH];
  longint        m_steps [CH];
  bit            m_os    [CH];
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_slow;
  logic [CH-1:0] m_done;

  int total = 0;
  int bad   = 0;

  logic [CH-1:0] th [64];
  logic [CH-1:0] sh [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      bit hit;
      hit = cfg.wr_en && (cfg.wr_ch == 4'(i));
      if (!n_reset) begin
        m_r[i] = DEF; m_os[i] = 1'b0; m_steps[i] = 0;
        m_tick[i] = 1'b0; m_slow[i] = 1'b0; m_done[i] = 1'b0;
      end else begin
        if (hit) begin
          m_r[i]  = longint'(cfg.wr_ratio);
          m_os[i] = cfg.wr_oneshot;
        end
        if (sync || hit) begin
          m_steps[i] = 0; m_tick[i] = 1'b0; m_done[i] = 1'b0;
          if (sync) m_slow[i] = 1'b0;
        end else if (en[i] && m_r[i] != 0 && !m_done[i]) begin
          m_steps[i]++;
          if (m_steps[i] % m_r[i] == 0) begin
            m_tick[i] = 1'b1;
            m_slow[i] = ~m_slow[i];
            if (m_os[i]) m_done[i] = 1'b1;
          end else begin
            m_tick[i] = 1'b0;
          end
        end else begin
          m_tick[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tick", 64'(tick), 64'(m_tick));
    check("slow_clock", 64'(slow_clock), 64'(m_slow));
    check("done", 64'(done), 64'(m_done));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      th[k] = tick;
      sh[k] = slow_clock;
    end
  endtask

  function automatic logic [63:0] hist(input int ch, input int n, input bit use_slow);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = use_slow ? sh[k][ch] : th[k][ch];
    return v;
  endfunction

  task automatic wr(input int ch, input longint unsigned r, input bit os);
    cfg.wr_en      = 1'b1;
    cfg.wr_ch      = 4'(ch);
    cfg.wr_ratio   = 32'(r);
    cfg.wr_oneshot = os;
    step();
    cfg.wr_en      = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s;
    int   first;
    bit   found;

    n_reset = 1'b0; en = '1; sync = 1'b0;
    cfg.wr_en = 1'b0; cfg.wr_ch = 4'd0; cfg.wr_ratio = 32'd0; cfg.wr_oneshot = 1'b0;

    // Reset held for one 10 ns edge, all channels enabled at DEFAULT_RATIO=2.
    step();
    check("reset_outputs", 64'({tick, slow_clock, done}), 64'd0);
    n_reset = 1'b1;
    run(8);
    for (int i = 0; i < CH; i++) begin
      check("default_tick", hist(i, 8, 1'b0), 64'b10101010);
      check("default_slow", hist(i, 8, 1'b1), 64'b01100110);
    end

    // ch1 R=3 periodic: ticks on cycles 3, 6, 9 after the write.
    wr(1, 3, 1'b0);
    run(9);
    check("ch1_r3", hist(1, 9, 1'b0), 64'b100100100);

    // ch2 R=4 one-shot, then re-armed by a second write.
    wr(2, 4, 1'b1);
    run(12);
    check("oneshot_tick", hist(2, 12, 1'b0), 64'b1000);
    check("oneshot_done", 64'(done[2]), 64'd1);
    wr(2, 4, 1'b1);
    check("oneshot_rearm", 64'(done[2]), 64'd0);
    run(8);
    check("oneshot_tick2", hist(2, 8, 1'b0), 64'b1000);

    // ch0 R=5 paused at count 2 for 7 cycles.
    wr(0, 5, 1'b0);
    run(2);
    en[0] = 1'b0;
    run(7);
    check("pause_silent", hist(0, 7, 1'b0), 64'd0);
    en[0] = 1'b1;
    run(3);
    check("pause_resume", hist(0, 3, 1'b0), 64'b100);

    // R=2,3,4,5 free-running, then sync.
    wr(0, 2, 1'b0);
    wr(2, 4, 1'b0);
    wr(3, 5, 1'b0);
    run(7);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_tick", 64'(tick), 64'd0);
    check("sync_slow", 64'(slow_clock), 64'd0);
    run(5);
    for (int i = 0; i < CH; i++) begin
      first = 99;
      for (int k = 4; k >= 0; k--) if (th[k][i]) first = k + 1;
      check("sync_first_tick", 64'(first), 64'(i + 2));
    end

    // Write landing on ch3's wrap cycle suppresses tick and toggle.
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!found) begin
        if (m_steps[3] % m_r[3] == m_r[3] - 1) found = 1'b1;
        else step();
      end
    end
    check("wrap_found", 64'(found), 64'd1);
    s = slow_clock[3];
    wr(3, 5, 1'b0);
    check("wrap_wr_tick", 64'(tick[3]), 64'd0);
    check("wrap_wr_slow", 64'(slow_clock[3]), 64'(s));

    // Out-of-range channel index: the model expects no change anywhere.
    wr(CH, 7, 1'b1);
    run(6);

    // R=0 halts ch1.
    wr(1, 0, 1'b0);
    s = slow_clock[1];
    run(10);
    check("r0_silent", hist(1, 10, 1'b0), 64'd0);
    check("r0_slow_held", 64'(slow_clock[1]), 64'(s));

    // R=1 ticks every cycle.
    wr(0, 1, 1'b0);
    s = slow_clock[0];
    run(6);
    check("r1_tick", hist(0, 6, 1'b0), 64'b111111);
    check("r1_slow", hist(0, 6, 1'b1), s ? 64'b101010 : 64'b010101);

    // Maximum ratio accepted without overflow.
    wr(1, 64'hFFFF_FFFF, 1'b0);
    run(5);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      en             = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '1;
      sync           = ($urandom_range(0, 29) == 0);
      cfg.wr_en      = ($urandom_range(0, 7) == 0);
      cfg.wr_ch      = 4'($urandom_range(0, 5));
      cfg.wr_ratio   = 32'($urandom_range(0, 6));
      cfg.wr_oneshot = 1'($urandom_range(0, 1));
      step();
    end
    sync = 1'b0; cfg.wr_en = 1'b0; en = '1;
    run(3);

    // Reset mid-count overrides a concurrent sync and write.
    n_reset = 1'b0; sync = 1'b1;
    cfg.wr_en = 1'b1; cfg.wr_ch = 4'd0; cfg.wr_ratio = 32'd7; cfg.wr_oneshot = 1'b1;
    step();
    check("reset_override", 64'({tick, slow_clock, done}), 64'd0);
    n_reset = 1'b1; sync = 1'b0; cfg.wr_en = 1'b0;
    run(4);
    check("reset_restart", hist(0, 4, 1'b0), 64'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
